// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed common-anode seven-segment scan controller.
// Drives NUM_DIGITS digits from a packed hex input. Decode covers 0-F, and each
// digit has its own decimal point. Updates are double-buffered: load fills the
// shadow buffer, and the active buffer copies it at each frame wrap.
// Optional feature macro: SEG7_BRIGHTNESS_EN adds a 16-step per-slot PWM
// brightness gate. When the macro is undefined, brightness is ignored.

// Hex nibble to active-low a..g segment pattern, one instance per digit.
module seg7_digit_dec (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Pure lookup; a segment is lit when its bit is 0.
  always_comb begin
    seg = 7'h7F;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// Scan controller top.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic                    frame_start
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [TW-1:0]                timer;
  logic [SW-1:0]                sel;
  logic                         slot_end;
  logic                         frame_wrap;
  logic [NUM_DIGITS-1:0][3:0]   shadow_dig, active_dig;
  logic [NUM_DIGITS-1:0]        shadow_dp, active_dp;
  logic [NUM_DIGITS-1:0][6:0]   dec_seg;
  logic                         gate_b;

  assign slot_end   = (timer == TW'(REFRESH_DIV - 1));
  assign frame_wrap = slot_end && (sel == SW'(NUM_DIGITS - 1));

  // Slot timer: counts 0..REFRESH_DIV-1, then returns to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        timer <= '0;
    else if (slot_end) timer <= '0;
    else               timer <= timer + 1'b1;
  end

  // Digit select advances once per slot and wraps after the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sel <= '0;
    else if (slot_end)
      sel <= (sel == SW'(NUM_DIGITS - 1)) ? '0 : sel + 1'b1;
  end

  // Shadow buffer. It recaptures on every cycle that load is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_dig <= '0;
      shadow_dp  <= '0;
    end else if (load) begin
      shadow_dig <= digits_in;
      shadow_dp  <= dp_in;
    end
  end

  // Active buffer takes the pre-edge shadow at the frame wrap. A load on that
  // same edge therefore lands one frame later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_dig <= '0;
      active_dp  <= '0;
    end else if (frame_wrap) begin
      active_dig <= shadow_dig;
      active_dp  <= shadow_dp;
    end
  end

  // Frame marker is high for the first cycle with sel back at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_start <= 1'b0;
    else        frame_start <= frame_wrap;
  end

`ifdef SEG7_BRIGHTNESS_EN
  localparam int PRE = REFRESH_DIV / 16;
  localparam int PW  = (PRE > 1) ? $clog2(PRE) : 1;

  logic [PW-1:0] pre_cnt;
  logic [3:0]    phase;
  logic [3:0]    bright_q;

  // PWM phase: 16 steps per slot, restarted at every slot boundary.
  // Brightness is latched at the same boundary so that a slot never changes
  // duty part-way through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt  <= '0;
      phase    <= '0;
      bright_q <= 4'hF;
    end else if (slot_end) begin
      pre_cnt  <= '0;
      phase    <= '0;
      bright_q <= brightness;
    end else if (pre_cnt == PW'(PRE - 1)) begin
      pre_cnt  <= '0;
      phase    <= phase + 1'b1;
    end else begin
      pre_cnt  <= pre_cnt + 1'b1;
    end
  end

  assign gate_b = (phase <= bright_q);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign gate_b = 1'b1;
`endif

  // Per-digit decoders. The select mux follows.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_digit_dec u_dec (
      .nib (active_dig[g]),
      .seg (dec_seg[g])
    );
  end

  // Registered pin drive. When the anode is gated off, segments and dp are
  // also blanked so the display does not ghost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg   <= 7'h7F;
      dp    <= 1'b1;
      digit <= '1;
    end else if (enable && gate_b) begin
      seg   <= dec_seg[sel];
      dp    <= ~active_dp[sel];
      digit <= ~(NUM_DIGITS'(1) << sel);
    end else begin
      seg   <= 7'h7F;
      dp    <= 1'b1;
      digit <= '1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=32).
// k counts rising edges since the last reset release. Sampling happens on the
// falling edge that follows edge k. The outputs after edge k reflect the
// counter state after edge k-1.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4*ND-1:0] digits_in = '0;
  logic [ND-1:0] dp_in = '0;
  logic          load = 1'b0;
  logic          enable = 1'b1;
  logic [3:0]    brightness = 4'hF;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] digit;
  logic          frame_start;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int on_cnt;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .load        (load),
    .enable      (enable),
    .brightness  (brightness),
    .seg         (seg),
    .dp          (dp),
    .digit       (digit),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) cyc();
  endtask

  task automatic chk_out(input string tag, input logic [6:0] s, input logic d, input logic [3:0] an);
    chk({tag, ".seg"},   32'(seg),   32'(s));
    chk({tag, ".dp"},    32'(dp),    32'(d));
    chk({tag, ".digit"}, 32'(digit), 32'(an));
  endtask

  initial begin
    // Reset state while rst_n is held low
    @(negedge clk);
    chk_out("rst", 7'h7F, 1'b1, 4'hF);
    chk("rst.fs", 32'(frame_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;

    // Blank buffers: every digit shows 0, and the anodes step through the digits
    run_to(1);   chk_out("scan0", 7'h40, 1'b1, 4'b1110);
    run_to(32);  chk("scan0_end", 32'(digit), 32'(4'b1110));
    run_to(33);  chk_out("scan1", 7'h40, 1'b1, 4'b1101);
    run_to(65);  chk_out("scan2", 7'h40, 1'b1, 4'b1011);
    run_to(97);  chk_out("scan3", 7'h40, 1'b1, 4'b0111);
    run_to(127); chk("fs_pre", 32'(frame_start), 32'd0);
    run_to(128); chk("fs_1", 32'(frame_start), 32'd1);
    run_to(129); chk("fs_post", 32'(frame_start), 32'd0);
    run_to(256); chk("fs_2", 32'(frame_start), 32'd1);

    // Mid-frame load of A5F3 with dp on digit 2; the display changes at the next wrap
    run_to(260);
    digits_in = 16'hA5F3; dp_in = 4'b0100; load = 1'b1;
    cyc(); load = 1'b0;
    run_to(383); chk_out("ld_old", 7'h40, 1'b1, 4'b0111);
    run_to(385); chk_out("ld_d0", 7'h30, 1'b1, 4'b1110);
    run_to(417); chk_out("ld_d1", 7'h0E, 1'b1, 4'b1101);
    run_to(449); chk_out("ld_d2", 7'h12, 1'b0, 4'b1011);
    run_to(481); chk_out("ld_d3", 7'h08, 1'b1, 4'b0111);

    // Load on the exact wrap edge (edge 512): 1234 is shown one frame later
    run_to(511);
    digits_in = 16'h1234; dp_in = 4'b0000; load = 1'b1;
    cyc(); load = 1'b0;
    run_to(513); chk_out("wr_old0", 7'h30, 1'b1, 4'b1110);
    run_to(545); chk_out("wr_old1", 7'h0E, 1'b1, 4'b1101);
    run_to(641); chk_out("wr_new0", 7'h19, 1'b1, 4'b1110);
    run_to(673); chk_out("wr_new1", 7'h30, 1'b1, 4'b1101);

    // Enable drop mid-slot blanks on the next edge; frame cadence is unchanged
    run_to(700);
    enable = 1'b0;
    cyc();       chk_out("en_off", 7'h7F, 1'b1, 4'hF);
    run_to(767); chk("en_fs_pre", 32'(frame_start), 32'd0);
    run_to(768); chk("en_fs", 32'(frame_start), 32'd1);
    run_to(770);
    enable = 1'b1;
    cyc();       chk_out("en_on", 7'h19, 1'b1, 4'b1110);

    // Brightness duty over a full slot (latched at edge 800, then at edge 864)
    run_to(775);
    brightness = 4'd3;
    run_to(800);
    on_cnt = 0;
    repeat (RD) begin cyc(); if (digit != 4'hF) on_cnt++; end
    brightness = 4'd15;
`ifdef SEG7_BRIGHTNESS_EN
    chk("duty_b3", 32'(on_cnt), 32'd8);
`else
    chk("duty_b3", 32'(on_cnt), 32'd32);
`endif
    run_to(864);
    on_cnt = 0;
    repeat (RD) begin cyc(); if (digit != 4'hF) on_cnt++; end
    chk("duty_b15", 32'(on_cnt), 32'd32);

    // Asynchronous reset mid-frame: outputs clear before the next clock edge
    run_to(900);
    #2 rst_n = 1'b0;
    #1;
    chk_out("arst", 7'h7F, 1'b1, 4'hF);
    chk("arst.fs", 32'(frame_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    run_to(1);   chk_out("post_rst0", 7'h40, 1'b1, 4'b1110);
    run_to(97);  chk_out("post_rst3", 7'h40, 1'b1, 4'b0111);
    run_to(127); chk("post_fs_pre", 32'(frame_start), 32'd0);
    run_to(128); chk("post_fs", 32'(frame_start), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
